framebuffer_scanout: RTL and testbench
======================================

FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 The module SHALL have parameter GFX_width, default 800, visible pixels per line.
REQ-002 The module SHALL have parameter GFX_height, default 480, visible lines per frame.
REQ-003 The module SHALL have parameter FB_BASE, default 24'h000000, framebuffer base address in 16-bit pixel units.
REQ-004 The module SHALL have these ports:
- pixclk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- nextX  in  11  display X of the next pixel, already clamped to GFX_width-1 during blanking.
- nextY  in  11  display Y of the next pixel, already clamped to GFX_height-1 during blanking.
- vSync  in  1  high during vertical sync.
- mem_req  out  1  read request to the framebuffer.
- mem_addr  out  24  pixel address of the request.
- mem_ack  in  1  one-cycle read-complete strobe.
- mem_rdata  in  16  RGB565 pixel; valid only while mem_ack=1.
- red, green, blue  out  8 each  pixel colour for the HDMI output stage.
- underrun  out  1  sticky error flag.
REQ-005 The clocking and reset scheme is fixed: one clock (pixclk); reset is asynchronous and active-high.

Function
REQ-006 The module SHALL hold two line banks of GFX_width x 16 bits, with bank b holding rows whose row[0]=b.
REQ-007 Display read: on each pixclk edge, the module SHALL read bank nextY[0] at index nextX and register the result, giving 1-cycle latency from nextX/nextY to red/green/blue.
REQ-008 Colour expansion SHALL be red={p[15:11],p[15:13]}, green={p[10:5],p[10:9]}, blue={p[4:0],p[4:2]}.
REQ-009 Fetch trigger A: a rising edge of vSync (registered previous value 0, current 1) SHALL start a fetch of row 0.
REQ-010 Fetch trigger B: when nextY differs from its registered previous value and the new value v satisfies v+1<GFX_height, the module SHALL start a fetch of row v+1.
REQ-011 Blanking SHALL start no fetch, because nextY stays clamped and v=GFX_height-1 never triggers.
REQ-012 The fetch FSM SHALL have states IDLE and FETCH:
- IDLE->FETCH on a trigger; this loads row r and sets col=0.
- In FETCH, mem_req=1 and mem_addr=FB_BASE+r*GFX_width+col; mem_addr SHALL stay stable until mem_ack.
- On mem_ack, mem_rdata SHALL be written to bank r[0] at col, and col SHALL increment.
- The ack for col=GFX_width-1 SHALL return the FSM to IDLE, with mem_req=0 from the next cycle.
REQ-013 The fetch SHALL have at most one outstanding request, and mem_ack SHALL be ignored while in IDLE.
REQ-014 mem_addr SHALL wrap modulo 2^24, and the row-base product SHALL be computed without truncation below 24 bits.
REQ-015 A trigger arriving while in FETCH SHALL abort the current row, restart at col=0 with the new row, and set underrun.
REQ-016 If a trigger and mem_ack occur in the same cycle while in FETCH, the ack data SHALL still be written for the old row, and the restart SHALL take priority for the next address.
REQ-017 underrun SHALL stay set until reset.
REQ-018 Bank writes and display reads SHALL be independent ports; when both address the same bank and index in the same cycle, the read value is unspecified (this occurs only under underrun).

Reset
REQ-019 While reset=1, the module SHALL force:
- mem_req=0, mem_addr=0, red=green=blue=0, underrun=0;
- FSM=IDLE, col=0;
- previous-vSync register=0 and previous-nextY register=GFX_height-1.
REQ-020 Reset asserted mid-fetch SHALL drop mem_req asynchronously, and the module SHALL ignore any later ack.
REQ-021 Bank contents SHALL NOT be cleared by reset.

Verification (GFX_width=8, GFX_height=4, FB_BASE=24'h000100, memory model acks 2 cycles after req)
REQ-022 Scenario: vSync 0->1 -> mem_addr steps 0x100..0x107, one request per ack; then mem_req=0 and bank0[0..7] equals memory.
REQ-023 Scenario: nextY 3->0 (no change in previous) then 0->1 -> fetch of row 1 starts at 0x108 after the first change; change to 3 fetches nothing.
REQ-024 Scenario: bank0[5]=16'hF800, nextY=0, nextX=5 -> next edge red=8'hFF, green=8'h00, blue=8'h00; pixel 16'h07E0 -> green=8'hFF.
REQ-025 Scenario: nextY change during a row-1 fetch at col=3 -> underrun=1, mem_addr jumps to the new row at col 0, and underrun stays 1 through later frames.
REQ-026 Scenario: reset pulsed while mem_req=1 -> mem_req=0 immediately; a late mem_ack causes no bank write; all outputs return to 0.

Source files
------------

// File: rtl/framebuffer_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : framebuffer_scanout
//  Purpose  : Double line-buffered framebuffer scan-out. Prefetches the next
//             display row from a 16-bit RGB565 framebuffer into one of two
//             line banks while the other bank is displayed, then expands the
//             pixel to 8-bit RGB with a single cycle of latency.
//  Ports    : pixclk, reset         - pixel clock, async active-high reset
//             nextX, nextY, vSync   - display timing (coords pre-clamped)
//             mem_req/addr/ack/rdata- one-outstanding-request read port
//             red, green, blue      - expanded pixel colour
//             underrun              - sticky: a row fetch was overtaken
//  Revision : 1.0 - initial release
// ============================================================================
module framebuffer_scanout #(
    parameter int          GFX_width  = 800,
    parameter int          GFX_height = 480,
    parameter logic [23:0] FB_BASE    = 24'h000000
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic [10:0] nextX,
    input  logic [10:0] nextY,
    input  logic        vSync,
    output logic        mem_req,
    output logic [23:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        underrun
);

    localparam int          c_idx_w    = (GFX_width > 1) ? $clog2(GFX_width) : 1;
    localparam logic [10:0] c_last_col = 11'(GFX_width - 1);
    localparam logic [10:0] c_width11  = 11'(GFX_width);
    localparam logic [11:0] c_height12 = 12'(GFX_height);
    localparam logic [23:0] c_width24  = 24'(GFX_width);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(GFX_width - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_row, w_row_nxt;
    logic [10:0] r_col, w_col_nxt;
    logic        r_underrun, w_underrun_nxt;
    logic        r_prev_vsync;
    logic [10:0] r_prev_y;
    logic [7:0]  r_red, r_green, r_blue;

    logic [15:0] r_bank0 [GFX_width];
    logic [15:0] r_bank1 [GFX_width];

    // ------------------------------------------------------------------
    // Fetch triggers. A new frame always begins with row 0; otherwise each
    // change of display line prefetches the line after it. Blanking keeps
    // nextY clamped at the last line, whose successor is out of range.
    // ------------------------------------------------------------------
    logic [11:0] w_ny_inc;
    logic        w_trig_a, w_trig_b, w_trig;
    logic [10:0] w_trig_row;
    logic        w_last_col;
    logic        w_bank_we;
    logic [23:0] w_fetch_addr;

    assign w_ny_inc   = {1'b0, nextY} + 12'd1;
    assign w_trig_a   = vSync & ~r_prev_vsync;
    assign w_trig_b   = (nextY != r_prev_y) && (w_ny_inc < c_height12);
    assign w_trig     = w_trig_a | w_trig_b;
    assign w_trig_row = w_trig_a ? 11'd0 : w_ny_inc[10:0];
    assign w_last_col = (r_col == c_last_col);
    // Acks are honoured only in FETCH, so stray acks after reset are dropped.
    assign w_bank_we  = (r_state == S_FETCH) && mem_ack;

    // 24-bit multiply keeps the full row base and wraps the sum modulo 2^24.
    assign w_fetch_addr = FB_BASE + (24'(r_row) * c_width24) + 24'(r_col);

    assign mem_req  = (r_state == S_FETCH);
    assign mem_addr = (r_state == S_FETCH) ? w_fetch_addr : 24'h000000;

    // ------------------------------------------------------------------
    // Fetch FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_underrun_nxt = r_underrun;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = S_FETCH;
                    w_row_nxt   = w_trig_row;
                    w_col_nxt   = 11'd0;
                end
            end
            S_FETCH: begin
                // A new trigger overtakes the running row; any ack in the
                // same cycle has still been written for the old row.
                if (w_trig) begin
                    w_row_nxt      = w_trig_row;
                    w_col_nxt      = 11'd0;
                    w_underrun_nxt = 1'b1;
                end else if (mem_ack) begin
                    if (w_last_col) begin
                        w_state_nxt = S_IDLE;
                        w_col_nxt   = 11'd0;
                    end else begin
                        w_col_nxt = r_col + 11'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_col_nxt   = 11'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch FSM and timing history registers
    // ------------------------------------------------------------------
    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_row        <= 11'd0;
            r_col        <= 11'd0;
            r_underrun   <= 1'b0;
            r_prev_vsync <= 1'b0;
            r_prev_y     <= 11'(GFX_height - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_underrun   <= w_underrun_nxt;
            r_prev_vsync <= vSync;
            r_prev_y     <= nextY;
        end
    end

    // ------------------------------------------------------------------
    // Line bank write port (contents deliberately survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge pixclk) begin
        if (w_bank_we) begin
            if (r_row[0]) begin
                r_bank1[r_col[c_idx_w-1:0]] <= mem_rdata;
            end else begin
                r_bank0[r_col[c_idx_w-1:0]] <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display read port and RGB565 -> RGB888 expansion. Upper bits are
    // replicated into the low bits so full-scale maps to 8'hFF.
    // ------------------------------------------------------------------
    logic [c_idx_w-1:0] w_rd_idx;
    logic [15:0]        w_rd_pix;

    assign w_rd_idx = (nextX < c_width11) ? nextX[c_idx_w-1:0] : c_last_idx;
    assign w_rd_pix = nextY[0] ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];

    always_ff @(posedge pixclk or posedge reset) begin
        if (reset) begin
            r_red   <= 8'h00;
            r_green <= 8'h00;
            r_blue  <= 8'h00;
        end else begin
            r_red   <= {w_rd_pix[15:11], w_rd_pix[15:13]};
            r_green <= {w_rd_pix[10:5],  w_rd_pix[10:9]};
            r_blue  <= {w_rd_pix[4:0],   w_rd_pix[4:2]};
        end
    end

    assign red      = r_red;
    assign green    = r_green;
    assign blue     = r_blue;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_framebuffer_scanout
//  Purpose  : Self-checking bench for framebuffer_scanout (8x4 display,
//             base 0x100). A framebuffer memory model acks two cycles after
//             a stable request; expected line banks are kept as whole rows
//             of the memory image and compared through the pixel outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout;

    localparam int          W    = 8;
    localparam int          H    = 4;
    localparam logic [23:0] BASE = 24'h000100;

    logic        pixclk = 1'b0;
    logic        reset  = 1'b1;
    logic [10:0] nextX  = 11'd0;
    logic [10:0] nextY  = 11'd3;
    logic        vSync  = 1'b0;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [7:0]  red, green, blue;
    logic        underrun;

    logic        model_ack   = 1'b0;
    logic [15:0] model_rdata = 16'h0;
    logic        man_ack     = 1'b0;
    logic [15:0] man_rdata   = 16'h0;
    bit          mem_en      = 1'b1;

    assign mem_ack   = model_ack | man_ack;
    assign mem_rdata = man_ack ? man_rdata : model_rdata;

    framebuffer_scanout #(
        .GFX_width (W),
        .GFX_height(H),
        .FB_BASE   (BASE)
    ) dut (
        .pixclk   (pixclk),
        .reset    (reset),
        .nextX    (nextX),
        .nextY    (nextY),
        .vSync    (vSync),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .underrun (underrun)
    );

    always #5 pixclk = ~pixclk;

    logic [15:0] mem [32];
    logic [15:0] exp_bank [2][W];
    int          total = 0;
    int          bad   = 0;
    int          ack_cnt = 0;
    logic [23:0] ack_q [$];

    // Memory model: a request whose address has been held for two further
    // cycles is acknowledged; an address change cancels the wait.
    bit          active = 1'b0;
    logic [23:0] last_addr = 24'h0;
    int          age = 0;
    always @(negedge pixclk) begin
        logic [23:0] off;
        if (!mem_en || reset || mem_req !== 1'b1) begin
            model_ack = 1'b0;
            active    = 1'b0;
        end else if (model_ack) begin
            model_ack = 1'b0;
            active    = 1'b1;
            last_addr = mem_addr;
            age       = 0;
        end else if (!active || mem_addr != last_addr) begin
            active    = 1'b1;
            last_addr = mem_addr;
            age       = 0;
        end else begin
            age++;
            if (age == 2) begin
                off         = mem_addr - BASE;
                model_rdata = mem[off[4:0]];
                model_ack   = 1'b1;
                ack_q.push_back(mem_addr);
                ack_cnt++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] exp_rgb(input logic [15:0] p);
        int r5, g6, b5, r, g, b;
        r5 = int'(p) / 2048;
        g6 = (int'(p) / 32) % 64;
        b5 = int'(p) % 32;
        r  = r5 * 8 + r5 / 4;
        g  = g6 * 4 + g6 / 16;
        b  = b5 * 8 + b5 / 4;
        return 32'(r * 65536 + g * 256 + b);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (mem_req === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, mem_req}, 32'd0);
    endtask

    // A completed fetch of row r leaves memory row r in bank r%2.
    task automatic fill_row(input int row);
        for (int c = 0; c < W; c++) exp_bank[row % 2][c] = mem[row * W + c];
    endtask

    task automatic check_line(input string tag);
        for (int x = 0; x < W; x++) begin
            nextX = 11'(x);
            tick();
            chk(tag, {8'd0, red, green, blue}, exp_rgb(exp_bank[nextY[0]][x]));
        end
    endtask

    initial begin
        int n0;
        int n;
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        mem[5] = 16'hF800;
        mem[6] = 16'h07E0;

        // Reset state
        repeat (3) tick();
        chk("rst_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_addr", {8'd0, mem_addr}, 32'd0);
        chk("rst_rgb",  {8'd0, red, green, blue}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        chk("idle_after_rst", {31'd0, mem_req}, 32'd0);

        // Frame start fetches row 0
        ack_q.delete();
        vSync = 1'b1;
        tick();
        chk("vs_req",   {31'd0, mem_req}, 32'd1);
        chk("vs_addr0", {8'd0, mem_addr}, 32'h100);
        wait_idle("vs_done");
        vSync = 1'b0;
        chk("vs_nacks", ack_q.size(), 32'd8);
        for (int i = 0; i < W; i++)
            chk("vs_ack_addr", {8'd0, ack_q[i]}, 32'h100 + 32'(i));
        fill_row(0);

        // Line 0 prefetches row 1 while displaying row 0
        nextY = 11'd0;
        nextX = 11'd0;
        tick();
        chk("y0_req",  {31'd0, mem_req}, 32'd1);
        chk("y0_addr", {8'd0, mem_addr}, 32'h108);
        check_line("row0_pix");
        nextX = 11'd5;
        tick();
        chk("red_full", {8'd0, red, green, blue}, 32'hFF0000);
        nextX = 11'd6;
        tick();
        chk("green_full", {8'd0, red, green, blue}, 32'h00FF00);
        wait_idle("row1_done");
        fill_row(1);

        nextY = 11'd1;
        tick();
        chk("y1_addr", {8'd0, mem_addr}, 32'h110);
        check_line("row1_pix");
        wait_idle("row2_done");
        fill_row(2);

        nextY = 11'd2;
        tick();
        chk("y2_addr", {8'd0, mem_addr}, 32'h118);
        check_line("row2_pix");
        wait_idle("row3_done");
        fill_row(3);

        // Last line (and blanking) fetch nothing
        nextY = 11'd3;
        n0 = ack_cnt;
        repeat (6) tick();
        chk("y3_noreq",  {31'd0, mem_req}, 32'd0);
        chk("y3_noacks", 32'(ack_cnt - n0), 32'd0);
        check_line("row3_pix");
        chk("no_underrun", {31'd0, underrun}, 32'd0);

        // Overtaking a row fetch at column 3
        nextY = 11'd0;
        n0 = ack_cnt;
        n = 0;
        while (ack_cnt - n0 < 3 && n < 100) begin
            tick();
            n++;
        end
        chk("ur_col3_addr", {8'd0, mem_addr}, 32'h10B);
        nextY = 11'd1;
        tick();
        chk("ur_flag", {31'd0, underrun}, 32'd1);
        chk("ur_restart_addr", {8'd0, mem_addr}, 32'h110);
        for (int c = 0; c < 3; c++) exp_bank[1][c] = mem[8 + c];
        wait_idle("ur_row2_done");
        fill_row(2);
        nextY = 11'd2;
        check_line("ur_row2_pix");
        wait_idle("ur_row3_done");
        fill_row(3);
        vSync = 1'b1;
        tick();
        vSync = 1'b0;
        chk("ur_sticky_a", {31'd0, underrun}, 32'd1);
        wait_idle("ur_row0_done");
        fill_row(0);
        chk("ur_sticky_b", {31'd0, underrun}, 32'd1);

        // Reset in the middle of a fetch, then a late ack
        mem_en = 1'b0;
        nextY  = 11'd0;
        tick();
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_req",  {31'd0, mem_req}, 32'd0);
        chk("async_addr", {8'd0, mem_addr}, 32'd0);
        chk("async_rgb",  {8'd0, red, green, blue}, 32'd0);
        chk("async_underrun", {31'd0, underrun}, 32'd0);
        nextY = 11'd3;
        nextX = 11'd0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        man_rdata = ~exp_bank[1][0];
        man_ack   = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("late_ack_noreq", {31'd0, mem_req}, 32'd0);
        tick();
        chk("bank_kept_c0", {8'd0, red, green, blue}, exp_rgb(exp_bank[1][0]));
        nextX = 11'd1;
        tick();
        chk("bank_kept_c1", {8'd0, red, green, blue}, exp_rgb(exp_bank[1][1]));
        mem_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
